// File: rtl/pio_cfg_loader.sv
// -----------------------------------------------------------------------------
// pio_cfg_loader
//
// Sequencer that sits directly in front of the pio configuration port. On a
// start pulse it streams a program image out of a synchronous instruction
// RAM as back-to-back INSTR writes. It then issues the PEND (exec_ctrl/wrap),
// DIV and GRPS writes, optionally an EN write, and returns the bus to NONE.
// This replaces hand-sequenced host writes at bring-up.
//
// Parameters
//   MAX_LEN      instruction memory depth; a plen above this is rejected
//   ENABLE_AFTER 1: finish the sequence with an EN action, 0: skip EN
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle load request, only honoured while idle
//   abort       in   cancel a load in progress
//   plen[5:0]   in   program length in instructions (1..MAX_LEN)
//   cfg_mindex  in   target state machine
//   exec_ctrl   in   data for the PEND action
//   div[23:0]   in   fractional clock divider for the DIV action
//   pin_grps    in   data for the GRPS action
//   en_mask     in   data for the EN action (zero-extended)
//   prog_addr   out  instruction RAM read address
//   prog_data   in   RAM read data, valid the cycle after prog_addr
//   action      out  pio action: NONE=0 INSTR=1 PEND=2 GRPS=5 EN=6 DIV=7
//   index       out  pio instruction slot
//   mindex      out  pio state machine select
//   din         out  pio action data
//   busy        out  high while a load is in progress
//   done        out  one-cycle pulse on successful completion
//   err         out  one-cycle pulse when start is rejected for a bad plen
//
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module pio_cfg_loader #(
    parameter int MAX_LEN      = 32,
    parameter int ENABLE_AFTER = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  plen,
    input  logic [1:0]  cfg_mindex,
    input  logic [31:0] exec_ctrl,
    input  logic [23:0] div,
    input  logic [31:0] pin_grps,
    input  logic [3:0]  en_mask,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [3:0]  action,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    output logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // pio action encodings
    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;

    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

    // Each state names the action that will be placed on the bus at the
    // next clock edge; the output registers therefore always show the
    // action belonging to the previous state.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_INSTR,
        S_PEND,
        S_DIV,
        S_GRPS,
        S_EN,
        S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // configuration captured at start and held for the whole load
    logic [5:0]  r_plen;
    logic [31:0] r_exec;
    logic [23:0] r_div;
    logic [31:0] r_grps;
    logic [3:0]  r_en;

    // instruction counter (slot being written next)
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_next;

    // output registers and their next values
    logic [4:0]  r_prog_addr;
    logic [4:0]  w_prog_addr_next;
    logic [3:0]  r_action;
    logic [3:0]  w_action_next;
    logic [4:0]  r_index;
    logic [4:0]  w_index_next;
    logic [1:0]  r_mindex;
    logic [1:0]  w_mindex_next;
    logic [31:0] r_din;
    logic [31:0] w_din_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_done;
    logic        w_done_next;
    logic        r_err;
    logic        w_err_next;

    // capture strobe for the configuration registers
    logic        w_latch;

    // helpers for the instruction stream
    logic        w_plen_bad;
    logic [5:0]  w_plen_m1;
    logic [5:0]  w_addr_ahead;
    logic [4:0]  w_addr_sat;
    logic        w_last_instr;

    assign w_plen_bad   = (plen == 6'd0) || ({1'b0, plen} > MAX_LEN_W);
    assign w_plen_m1    = r_plen - 6'd1;
    assign w_last_instr = ({1'b0, r_cnt} == w_plen_m1);

    // The RAM address runs two slots ahead of the slot being emitted now
    // (one slot of read latency plus the slot emitted at the next edge).
    // It stops at the last valid slot so it never wraps past 31.
    assign w_addr_ahead = {1'b0, r_cnt} + 6'd2;
    assign w_addr_sat   = (w_addr_ahead > w_plen_m1) ? w_plen_m1[4:0]
                                                     : w_addr_ahead[4:0];

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_prog_addr_next = r_prog_addr;
        w_action_next    = ACT_NONE;
        w_index_next     = r_index;
        w_mindex_next    = r_mindex;
        w_din_next       = 32'd0;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;
        w_latch          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_plen_bad) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_latch          = 1'b1;
                        w_mindex_next    = cfg_mindex;
                        w_prog_addr_next = 5'd0;
                        w_cnt_next       = 5'd0;
                        w_busy_next      = 1'b1;
                        w_state_next     = S_FETCH;
                    end
                end
            end

            // Address 0 is being read this cycle; present address 1 so the
            // stream is already one ahead when the first INSTR goes out.
            S_FETCH: begin
                w_prog_addr_next = (r_plen > 6'd1) ? 5'd1 : 5'd0;
                w_state_next     = S_INSTR;
            end

            S_INSTR: begin
                w_action_next    = ACT_INSTR;
                w_index_next     = r_cnt;
                w_din_next       = {16'd0, prog_data};
                w_prog_addr_next = w_addr_sat;
                if (w_last_instr) begin
                    w_state_next = S_PEND;
                end else begin
                    w_cnt_next   = r_cnt + 5'd1;
                end
            end

            S_PEND: begin
                w_action_next = ACT_PEND;
                w_din_next    = r_exec;
                w_state_next  = S_DIV;
            end

            S_DIV: begin
                w_action_next = ACT_DIV;
                w_din_next    = {8'd0, r_div};
                w_state_next  = S_GRPS;
            end

            S_GRPS: begin
                w_action_next = ACT_GRPS;
                w_din_next    = r_grps;
                w_state_next  = (ENABLE_AFTER != 0) ? S_EN : S_FIN;
            end

            S_EN: begin
                w_action_next = ACT_EN;
                w_din_next    = {28'd0, r_en};
                w_state_next  = S_FIN;
            end

            S_FIN: begin
                w_busy_next  = 1'b0;
                w_done_next  = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase

        // Abort overrides whatever progression the state would have made,
        // including the final done pulse.
        if (abort && (r_state != S_IDLE)) begin
            w_state_next  = S_IDLE;
            w_action_next = ACT_NONE;
            w_din_next    = 32'd0;
            w_index_next  = r_index;
            w_busy_next   = 1'b0;
            w_done_next   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_prog_addr <= 5'd0;
            r_action    <= ACT_NONE;
            r_index     <= 5'd0;
            r_mindex    <= 2'd0;
            r_din       <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_prog_addr <= w_prog_addr_next;
            r_action    <= w_action_next;
            r_index     <= w_index_next;
            r_mindex    <= w_mindex_next;
            r_din       <= w_din_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
        end
    end

    // Configuration snapshot; only loaded on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plen <= 6'd0;
            r_exec <= 32'd0;
            r_div  <= 24'd0;
            r_grps <= 32'd0;
            r_en   <= 4'd0;
        end else if (w_latch) begin
            r_plen <= plen;
            r_exec <= exec_ctrl;
            r_div  <= div;
            r_grps <= pin_grps;
            r_en   <= en_mask;
        end
    end

    assign prog_addr = r_prog_addr;
    assign action    = r_action;
    assign index     = r_index;
    assign mindex    = r_mindex;
    assign din       = r_din;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_pio_cfg_loader.sv
// -----------------------------------------------------------------------------
// Directed bench for pio_cfg_loader. Two instances: dut1 ends its sequence
// with EN, dut0 skips EN. Each has its own synchronous instruction RAM read
// port onto a shared program image.
// -----------------------------------------------------------------------------
module tb_pio_cfg_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start0, abort;
    logic [5:0]  plen;
    logic [1:0]  cfg_mindex;
    logic [31:0] exec_ctrl;
    logic [23:0] div;
    logic [31:0] pin_grps;
    logic [3:0]  en_mask;

    logic [4:0]  pa1, pa0;
    logic [15:0] pd1, pd0;
    logic [3:0]  act1, act0;
    logic [4:0]  idx1, idx0;
    logic [1:0]  mi1, mi0;
    logic [31:0] din1, din0;
    logic        busy1, busy0, done1, done0, err1, err0;

    logic [15:0] ram [32];

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_act [6];
    logic [31:0] exp_din [6];
    logic        seen_done;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pd1 <= ram[pa1];
        pd0 <= ram[pa0];
    end

    pio_cfg_loader #(.MAX_LEN(32), .ENABLE_AFTER(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort),
        .plen(plen), .cfg_mindex(cfg_mindex), .exec_ctrl(exec_ctrl),
        .div(div), .pin_grps(pin_grps), .en_mask(en_mask),
        .prog_addr(pa1), .prog_data(pd1),
        .action(act1), .index(idx1), .mindex(mi1), .din(din1),
        .busy(busy1), .done(done1), .err(err1)
    );

    pio_cfg_loader #(.MAX_LEN(32), .ENABLE_AFTER(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort),
        .plen(plen), .cfg_mindex(cfg_mindex), .exec_ctrl(exec_ctrl),
        .div(div), .pin_grps(pin_grps), .en_mask(en_mask),
        .prog_addr(pa0), .prog_data(pd0),
        .action(act0), .index(idx0), .mindex(mi0), .din(din0),
        .busy(busy0), .done(done0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start1 = 1'b0; start0 = 1'b0; abort = 1'b0;
        plen = 6'd2; cfg_mindex = 2'd0; exec_ctrl = 32'h0000_1000;
        div = 24'h000280; pin_grps = 32'h0400_0000; en_mask = 4'h1;
        for (int i = 0; i < 32; i++) ram[i] = 16'h0;
        ram[0] = 16'hE081;
        ram[1] = 16'hE001;

        // ---------------- reset state ----------------
        #2;
        chk("rst_action", {28'd0, act1}, 32'd0);
        chk("rst_din", din1, 32'd0);
        chk("rst_flags", {29'd0, busy1, done1, err1}, 32'd0);
        chk("rst_addr", {27'd0, pa1}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // ---------------- bad plen rejected ----------------
        plen = 6'd0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("plen0_err", {31'd0, err1}, 32'd1);
        chk("plen0_busy", {31'd0, busy1}, 32'd0);
        chk("plen0_act", {28'd0, act1}, 32'd0);
        step();
        chk("plen0_err_clr", {31'd0, err1}, 32'd0);
        chk("plen0_addr", {27'd0, pa1}, 32'd0);

        plen = 6'd33;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("plen33_err", {31'd0, err1}, 32'd1);
        chk("plen33_busy", {31'd0, busy1}, 32'd0);
        step();
        chk("plen33_err_clr", {31'd0, err1}, 32'd0);
        chk("plen33_act", {28'd0, act1}, 32'd0);
        chk("plen33_addr", {27'd0, pa1}, 32'd0);

        // ---------------- basic two-instruction load ----------------
        exp_act[0] = 4'd1; exp_din[0] = 32'h0000_E081;
        exp_act[1] = 4'd1; exp_din[1] = 32'h0000_E001;
        exp_act[2] = 4'd2; exp_din[2] = 32'h0000_1000;
        exp_act[3] = 4'd7; exp_din[3] = 32'h0000_0280;
        exp_act[4] = 4'd5; exp_din[4] = 32'h0400_0000;
        exp_act[5] = 4'd6; exp_din[5] = 32'h0000_0001;
        plen = 6'd2;
        start1 = 1'b1;
        step();                                 // edge 0
        start1 = 1'b0;
        chk("p2_busy_e0", {31'd0, busy1}, 32'd1);
        chk("p2_act_e0", {28'd0, act1}, 32'd0);
        step();                                 // edge 1
        chk("p2_act_e1", {28'd0, act1}, 32'd0);
        for (int e = 2; e <= 7; e++) begin
            step();
            chk($sformatf("p2_act_e%0d", e), {28'd0, act1}, {28'd0, exp_act[e-2]});
            chk($sformatf("p2_din_e%0d", e), din1, exp_din[e-2]);
            if (e < 4) chk($sformatf("p2_idx_e%0d", e), {27'd0, idx1}, e - 2);
            chk($sformatf("p2_done_e%0d", e), {31'd0, done1}, 32'd0);
        end
        step();                                 // edge 8
        chk("p2_act_e8", {28'd0, act1}, 32'd0);
        chk("p2_din_e8", din1, 32'd0);
        chk("p2_done_e8", {31'd0, done1}, 32'd1);
        chk("p2_busy_e8", {31'd0, busy1}, 32'd0);
        chk("p2_addr_sat", {27'd0, pa1}, 32'd1);
        step();
        chk("p2_done_e9", {31'd0, done1}, 32'd0);
        chk("p2_idx_hold", {27'd0, idx1}, 32'd1);

        // ---------------- full-length load, inputs changed while busy ----------------
        for (int i = 0; i < 32; i++) ram[i] = 16'h1000 + 16'(i);
        plen = 6'd32;
        cfg_mindex = 2'd2;
        start1 = 1'b1;
        step();                                 // edge 0
        start1 = 1'b0;
        exec_ctrl = 32'hDEAD_BEEF;
        cfg_mindex = 2'd1;
        plen = 6'd3;
        step();                                 // edge 1
        for (int e = 2; e <= 33; e++) begin
            step();
            chk($sformatf("p32_act_%0d", e - 2), {28'd0, act1}, 32'd1);
            chk($sformatf("p32_idx_%0d", e - 2), {27'd0, idx1}, e - 2);
            chk($sformatf("p32_din_%0d", e - 2), din1, 32'h1000 + e - 2);
        end
        chk("p32_mindex", {30'd0, mi1}, 32'd2);
        step();                                 // edge 34
        chk("p32_pend_act", {28'd0, act1}, 32'd2);
        chk("p32_pend_din", din1, 32'h0000_1000);
        step();                                 // edge 35
        chk("p32_div_act", {28'd0, act1}, 32'd7);
        step();                                 // edge 36
        chk("p32_grps_act", {28'd0, act1}, 32'd5);
        step();                                 // edge 37
        chk("p32_en_act", {28'd0, act1}, 32'd6);
        chk("p32_done_e37", {31'd0, done1}, 32'd0);
        step();                                 // edge 38
        chk("p32_done_e38", {31'd0, done1}, 32'd1);
        chk("p32_addr_sat", {27'd0, pa1}, 32'd31);
        exec_ctrl = 32'h0000_1000;
        cfg_mindex = 2'd0;
        step();

        // ---------------- abort during INSTR index 3 ----------------
        plen = 6'd8;
        start1 = 1'b1;
        step();                                 // edge 0
        start1 = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        chk("ab_idx3", {27'd0, idx1}, 32'd3);
        chk("ab_din3", din1, 32'h0000_1003);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_act", {28'd0, act1}, 32'd0);
        chk("ab_busy", {31'd0, busy1}, 32'd0);
        seen_done = done1;
        for (int e = 0; e < 12; e++) begin
            step();
            seen_done = seen_done | done1 | busy1;
        end
        chk("ab_quiet", {31'd0, seen_done}, 32'd0);
        start1 = 1'b1;
        step();                                 // edge 0 of reload
        start1 = 1'b0;
        step();
        step();                                 // edge 2
        chk("ab_reload_idx", {27'd0, idx1}, 32'd0);
        chk("ab_reload_din", din1, 32'h0000_1000);
        for (int e = 3; e <= 14; e++) step();
        chk("ab_reload_done", {31'd0, done1}, 32'd1);

        // ---------------- asynchronous reset during DIV ----------------
        plen = 6'd2;
        start1 = 1'b1;
        step();                                 // edge 0
        start1 = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        chk("ar_div_act", {28'd0, act1}, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_act", {28'd0, act1}, 32'd0);
        chk("ar_din", din1, 32'd0);
        chk("ar_flags", {29'd0, busy1, done1, err1}, 32'd0);
        step();
        reset = 1'b0;
        seen_done = 1'b0;
        for (int e = 0; e < 6; e++) begin
            step();
            seen_done = seen_done | done1 | busy1 | (act1 != 4'd0);
        end
        chk("ar_idle", {31'd0, seen_done}, 32'd0);

        // ---------------- ENABLE_AFTER=0, start+abort, restart while busy ----------------
        ram[0] = 16'h00A5;
        ram[1] = 16'h005A;
        start0 = 1'b1;
        abort = 1'b1;
        step();                                 // edge 0
        start0 = 1'b0;
        abort = 1'b0;
        chk("e0_busy", {31'd0, busy0}, 32'd1);
        step();                                 // edge 1
        start0 = 1'b1;
        step();                                 // edge 2, start ignored
        start0 = 1'b0;
        chk("e0_instr0", din0, 32'h0000_00A5);
        step();                                 // edge 3
        chk("e0_instr1", din0, 32'h0000_005A);
        step();                                 // edge 4
        chk("e0_pend", {28'd0, act0}, 32'd2);
        step();                                 // edge 5
        chk("e0_div", {28'd0, act0}, 32'd7);
        step();                                 // edge 6
        chk("e0_grps", {28'd0, act0}, 32'd5);
        chk("e0_grps_din", din0, 32'h0400_0000);
        step();                                 // edge 7
        chk("e0_fin_act", {28'd0, act0}, 32'd0);
        chk("e0_done", {31'd0, done0}, 32'd1);
        chk("e0_busy_fin", {31'd0, busy0}, 32'd0);
        step();                                 // edge 8
        chk("e0_after", {30'd0, busy0, done0}, 32'd0);
        chk("e0_after_act", {28'd0, act0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_cfg_loader.md
Name: pio_cfg_loader

Overview:
- Sequencer directly upstream of the `pio` block; drives its `action`/`index`/`mindex`/`din` configuration port.
- On a start pulse, reads a program image from a synchronous instruction RAM and issues the INSTR writes back-to-back.
- Then issues the PEND (exec_ctrl/wrap), DIV, GRPS writes and optionally EN for one state machine, returning the bus to NONE.
- Replaces hand-sequenced host writes at bring-up.

Parameters:
- MAX_LEN, 32, instruction memory depth; plen above this is an error.
- ENABLE_AFTER, 1, when 1 the sequence ends with an EN action; when 0 EN is skipped.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin loading; ignored unless idle
- abort  input  1  cancel load in progress
- plen  input  6  program length in instructions, valid range 1..MAX_LEN
- cfg_mindex  input  2  target state machine
- exec_ctrl  input  32  value for PEND action
- div  input  24  fractional clock divider for DIV action
- pin_grps  input  32  value for GRPS action
- en_mask  input  4  value for EN action (zero-extended into din)
- prog_addr  output  5  instruction RAM read address
- prog_data  input  16  RAM read data; valid the cycle after prog_addr is presented
- action  output  4  to pio: NONE=0 INSTR=1 PEND=2 GRPS=5 EN=6 DIV=7
- index  output  5  to pio: instruction slot
- mindex  output  2  to pio: state machine select
- din  output  32  to pio: action data
- busy  output  1  high while loading
- done  output  1  one-cycle pulse on successful completion
- err  output  1  one-cycle pulse when start is rejected for bad plen

Behaviour:
- All outputs are registered. On reset all outputs are 0, including action=NONE and prog_addr=0, and the state is IDLE. Reset mid-load aborts immediately; no further actions are issued.
- States: IDLE, FETCH, INSTR, PEND, DIV, GRPS, EN, FIN.
- IDLE, start=1:
  - If plen==0 or plen>MAX_LEN: pulse err next cycle and stay IDLE.
  - Otherwise: latch plen, cfg_mindex, exec_ctrl, div, pin_grps, en_mask. Set prog_addr<=0, busy<=1, and go to FETCH.
- Latched values are used for the whole load; input changes while busy have no effect. start while busy is ignored.
- FETCH (1 cycle): prog_addr<=1, go to INSTR. This covers the RAM latency.
- INSTR, one per cycle for i=0..plen-1:
  - Outputs: action=INSTR, index=i, din={16'b0, prog_data}, mindex=latched cfg_mindex.
  - prog_addr runs one ahead and saturates at plen-1 (no wrap past 31).
  - After index plen-1, go to PEND.
- PEND: action=PEND, din=exec_ctrl.
- DIV: action=DIV, din={8'b0, div}.
- GRPS: action=GRPS, din=pin_grps.
- EN: action=EN, din={28'b0, en_mask}. This state is skipped when ENABLE_AFTER=0.
- FIN: action=NONE, din=0, busy<=0, done<=1 for one cycle. Then IDLE.
- Each non-NONE action is held for exactly one cycle; there are no idle gaps between consecutive actions.
- Timing (start sampled at edge 0): first INSTR is visible after edge 2. For ENABLE_AFTER=1, done is visible after edge plen+6; for ENABLE_AFTER=0, after edge plen+5.
- In IDLE: action=NONE, din=0, index holds its last value.
- abort=1 in any busy state: next cycle action=NONE, busy=0, no done, state IDLE. abort wins over same-cycle state progression. abort in IDLE has no effect.
- start and abort high together in IDLE: start is honoured.

Test Plan:
- RAM={E081,E001}, plen=2, exec_ctrl=0x00001000, div=0x000280, pin_grps=0x04000000, en_mask=1, cfg_mindex=0, ENABLE_AFTER=1, start at edge 0 -> required response:
  - after edges 2..7: (1,idx0,0xE081), (1,idx1,0xE001), (2,0x1000), (7,0x280), (5,0x04000000), (6,0x1);
  - after edge 8: NONE with done=1 and busy=0.
- plen=32 with RAM[i]=0x1000+i -> 32 consecutive INSTRs with index i and din 0x1000+i; prog_addr never exceeds 31; done after edge 38.
- plen=0 and plen=33 -> err pulses once, busy stays 0, action stays NONE, no RAM reads beyond address 0.
- abort asserted during INSTR index 3 of plen=8 -> next cycle action=NONE, busy=0, done never pulses; a later start reloads from index 0.
- reset asserted asynchronously mid-DIV -> action, din, busy, done, err drop to 0 without a clock edge; state returns to IDLE.
- start pulsed again while busy, with ENABLE_AFTER=0 -> second start ignored; sequence ends GRPS then NONE; done after edge plen+5.
